// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator call scheduler.
// Calls are scanned through a fixed 16-floor view so one helper serves
// every FLOORS setting; callers zero-extend their vectors into it.
package elevator_pkg;

    localparam int MAX_FLOORS = 16;
    localparam int MAX_FW     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    // True when any call is latched strictly above the given floor.
    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] pending,
                                         input logic [MAX_FW-1:0]     floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ((i > int'(floor)) && pending[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // True when any call is latched strictly below the given floor.
    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] pending,
                                         input logic [MAX_FW-1:0]     floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ((i < int'(floor)) && pending[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_travel_timer.sv
// Loadable up/down counter with a terminal-count flag. Used once as the
// per-floor travel timer (counts up) and once as the door dwell timer
// (loads, then counts down). Priority: clear, load, increment, decrement.
module elevator_travel_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler for the elevator car: latches floor calls, tracks the
// car position, chooses travel direction and sequences the door dwell.
// Car commands are decoded from the state register alone.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 4,
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 4,
    parameter int FW            = $clog2(FLOORS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [FLOORS-1:0] Call_Req,
    input  logic              Top_Limit_Hit,
    input  logic              Bottom_Limit_Hit,
    output logic              Go_Up,
    output logic              Go_Down,
    output logic              Halt,
    output logic [FW-1:0]     Current_Floor,
    output logic [FLOORS-1:0] Pending,
    output logic              Door_Open,
    output logic              Dir_Up
);

    localparam int            TW        = $clog2(TRAVEL_CYCLES + 1);
    localparam int            DW        = $clog2(DOOR_CYCLES + 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

    state_t            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic              dir_up_q, dir_up_d;

    logic [FLOORS-1:0]     set_mask, clr_mask;
    logic [MAX_FLOORS-1:0] pend_ext;
    logic [FW-1:0]         arr_floor;
    logic                  arrive;
    logic                  trv_clr, trv_inc, trv_tc;
    logic                  door_load, door_dec, door_tc;

    function automatic logic [MAX_FW-1:0] fidx(input logic [FW-1:0] f);
        return MAX_FW'(f);
    endfunction

    assign pend_ext = MAX_FLOORS'(pending_q);

    // Next-state, position, direction and call-latch computation.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        set_mask  = Call_Req;
        clr_mask  = '0;
        arr_floor = floor_q;
        arrive    = 1'b0;
        trv_clr   = 1'b0;
        trv_inc   = 1'b0;
        door_load = 1'b0;
        door_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                // A call at the floor we're parked on just opens the door.
                set_mask[floor_q] = 1'b0;
                trv_clr           = 1'b1;
                if (Top_Limit_Hit) begin
                    floor_d = TOP_FLOOR;
                end else if (Bottom_Limit_Hit) begin
                    floor_d = '0;
                end
                if (pending_q[floor_q] || Call_Req[floor_q]) begin
                    state_d = DOOR;
                end else if (calls_above(pend_ext, fidx(floor_q)) &&
                             (dir_up_q || !calls_below(pend_ext, fidx(floor_q)))) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (calls_below(pend_ext, fidx(floor_q))) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (Top_Limit_Hit) begin
                    arrive    = 1'b1;
                    arr_floor = TOP_FLOOR;
                    trv_clr   = 1'b1;
                end else if (trv_tc) begin
                    arrive    = 1'b1;
                    arr_floor = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FW'(1);
                    trv_clr   = 1'b1;
                end else begin
                    trv_inc = 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (Bottom_Limit_Hit) begin
                    arrive    = 1'b1;
                    arr_floor = '0;
                    trv_clr   = 1'b1;
                end else if (trv_tc) begin
                    arrive    = 1'b1;
                    arr_floor = (floor_q == '0) ? floor_q : floor_q - FW'(1);
                    trv_clr   = 1'b1;
                end else begin
                    trv_inc = 1'b1;
                end
            end
            DOOR: begin
                // A fresh call at this floor keeps the door open instead.
                set_mask[floor_q] = 1'b0;
                trv_clr           = 1'b1;
                if (Top_Limit_Hit) begin
                    floor_d = TOP_FLOOR;
                end else if (Bottom_Limit_Hit) begin
                    floor_d = '0;
                end
                if (Call_Req[floor_q]) begin
                    door_load = 1'b1;
                end else if (door_tc) begin
                    state_d = IDLE;
                end else begin
                    door_dec = 1'b1;
                end
            end
            default: ;
        endcase

        // Arrival at a new floor: stop if wanted, park if nothing lies ahead.
        if (arrive) begin
            floor_d = arr_floor;
            if (pending_q[arr_floor] || Call_Req[arr_floor]) begin
                state_d = DOOR;
            end else if ((state_q == MOVE_UP) ? !calls_above(pend_ext, fidx(arr_floor))
                                              : !calls_below(pend_ext, fidx(arr_floor))) begin
                state_d = IDLE;
            end
        end

        // Door entry serves the floor: clear its call (wins over a new set).
        if ((state_d == DOOR) && (state_q != DOOR)) begin
            door_load           = 1'b1;
            clr_mask[arr_floor] = 1'b1;
        end

        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    // Scheduler state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
        end
    end

    elevator_travel_timer #(.W(TW)) u_travel_timer (
        .clk      (CLK),
        .srst     (RESET),
        .clr      (trv_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (trv_inc),
        .dec      (1'b0),
        .term     (TW'(TRAVEL_CYCLES - 1)),
        .tc       (trv_tc)
    );

    elevator_travel_timer #(.W(DW)) u_door_timer (
        .clk      (CLK),
        .srst     (RESET),
        .clr      (1'b0),
        .load     (door_load),
        .load_val (DW'(DOOR_CYCLES - 1)),
        .inc      (1'b0),
        .dec      (door_dec),
        .term     ('0),
        .tc       (door_tc)
    );

    // Moore output decode.
    always_comb begin
        Go_Up     = (state_q == MOVE_UP);
        Go_Down   = (state_q == MOVE_DOWN);
        Halt      = (state_q == IDLE) || (state_q == DOOR);
        Door_Open = (state_q == DOOR);
    end

    assign Current_Floor = floor_q;
    assign Pending       = pending_q;
    assign Dir_Up        = dir_up_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed testbench for elevator_scheduler with a cycle-level behavioural
// model of the car (position, travel progress, door time left, call set).
module tb_elevator_scheduler;

    localparam int FLOORS        = 4;
    localparam int TRAVEL_CYCLES = 3;
    localparam int DOOR_CYCLES   = 4;
    localparam int FW            = 2;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic              clk;
    logic              RESET;
    logic [FLOORS-1:0] Call_Req;
    logic              Top_Limit_Hit;
    logic              Bottom_Limit_Hit;
    logic              Go_Up;
    logic              Go_Down;
    logic              Halt;
    logic [FW-1:0]     Current_Floor;
    logic [FLOORS-1:0] Pending;
    logic              Door_Open;
    logic              Dir_Up;

    int checks = 0;
    int errors = 0;

    elevator_scheduler #(
        .FLOORS        (FLOORS),
        .TRAVEL_CYCLES (TRAVEL_CYCLES),
        .DOOR_CYCLES   (DOOR_CYCLES),
        .FW            (FW)
    ) dut (
        .CLK              (clk),
        .RESET            (RESET),
        .Call_Req         (Call_Req),
        .Top_Limit_Hit    (Top_Limit_Hit),
        .Bottom_Limit_Hit (Bottom_Limit_Hit),
        .Go_Up            (Go_Up),
        .Go_Down          (Go_Down),
        .Halt             (Halt),
        .Current_Floor    (Current_Floor),
        .Pending          (Pending),
        .Door_Open        (Door_Open),
        .Dir_Up           (Dir_Up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state;
    int         m_floor;
    bit [3:0]   m_pend;
    bit         m_dir;
    int         m_moved;
    int         m_door_left;
    bit         m_valid = 1'b0;

    function automatic bit any_above(input bit [3:0] p, input int f);
        for (int i = f + 1; i < FLOORS; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input bit [3:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit [3:0] np;
        int       nf;
        bit       halted;
        bit       up;
        bit       arrived;
        if (RESET) begin
            m_state = M_IDLE; m_floor = 0; m_pend = '0; m_dir = 1'b1;
            m_moved = 0; m_door_left = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            np = m_pend;
            nf = m_floor;
            halted = (m_state == M_IDLE) || (m_state == M_DOOR);
            for (int i = 0; i < FLOORS; i++)
                if (Call_Req[i] && !(halted && i == m_floor)) np[i] = 1'b1;
            case (m_state)
                M_IDLE: begin
                    if (m_pend[m_floor] || Call_Req[m_floor]) begin
                        m_state = M_DOOR; m_door_left = DOOR_CYCLES; np[m_floor] = 1'b0;
                    end else if (any_above(m_pend, m_floor) && (m_dir || !any_below(m_pend, m_floor))) begin
                        m_state = M_UP; m_dir = 1'b1; m_moved = 0;
                    end else if (any_below(m_pend, m_floor)) begin
                        m_state = M_DOWN; m_dir = 1'b0; m_moved = 0;
                    end
                    if (Top_Limit_Hit) nf = FLOORS - 1;
                    else if (Bottom_Limit_Hit) nf = 0;
                end
                M_UP, M_DOWN: begin
                    up = (m_state == M_UP);
                    m_moved++;
                    arrived = 1'b0;
                    if (up && Top_Limit_Hit) begin
                        nf = FLOORS - 1; arrived = 1'b1;
                    end else if (!up && Bottom_Limit_Hit) begin
                        nf = 0; arrived = 1'b1;
                    end else if (m_moved == TRAVEL_CYCLES) begin
                        if (up) nf = (m_floor + 1 > FLOORS - 1) ? FLOORS - 1 : m_floor + 1;
                        else    nf = (m_floor - 1 < 0) ? 0 : m_floor - 1;
                        arrived = 1'b1;
                    end
                    if (arrived) begin
                        m_moved = 0;
                        if (m_pend[nf] || Call_Req[nf]) begin
                            m_state = M_DOOR; m_door_left = DOOR_CYCLES; np[nf] = 1'b0;
                        end else if (up ? !any_above(m_pend, nf) : !any_below(m_pend, nf)) begin
                            m_state = M_IDLE;
                        end
                    end
                end
                default: begin
                    if (Call_Req[m_floor]) m_door_left = DOOR_CYCLES;
                    else if (m_door_left == 1) m_state = M_IDLE;
                    else m_door_left--;
                    if (Top_Limit_Hit) nf = FLOORS - 1;
                    else if (Bottom_Limit_Hit) nf = 0;
                end
            endcase
            m_pend  = np;
            m_floor = nf;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("go_up",     32'(Go_Up),     32'(m_state == M_UP));
            check("go_down",   32'(Go_Down),   32'(m_state == M_DOWN));
            check("halt",      32'(Halt),      32'((m_state == M_IDLE) || (m_state == M_DOOR)));
            check("door_open", 32'(Door_Open), 32'(m_state == M_DOOR));
            check("floor",     32'(Current_Floor), 32'(m_floor));
            check("pending",   32'(Pending),   32'(m_pend));
            check("dir_up",    32'(Dir_Up),    32'(m_dir));
            check("onehot",    32'(Go_Up) + 32'(Go_Down) + 32'(Halt), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        RESET = 1'b1; Call_Req = '0; Top_Limit_Hit = 1'b0; Bottom_Limit_Hit = 1'b0;
        ticks(2);
        check("rst_halt",    32'(Halt), 32'd1);
        check("rst_go_up",   32'(Go_Up), 32'd0);
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_floor",   32'(Current_Floor), 32'd0);
        check("rst_dir",     32'(Dir_Up), 32'd1);
        check("rst_door",    32'(Door_Open), 32'd0);
        RESET = 1'b0;

        // 1: single call at floor 2 from floor 0
        ticks(1); Call_Req = 4'b0100;                        // n
        ticks(1); Call_Req = '0;                             // n+1
        check("t1_pend_n1", 32'(Pending), 32'h4);
        ticks(1);                                            // n+2
        check("t1_goup_n2", 32'(Go_Up), 32'd1);
        ticks(3);                                            // n+5
        check("t1_floor_n5", 32'(Current_Floor), 32'd1);
        ticks(3);                                            // n+8
        check("t1_floor_n8", 32'(Current_Floor), 32'd2);
        check("t1_door_n8",  32'(Door_Open), 32'd1);
        check("t1_pend_n8",  32'(Pending), 32'd0);
        ticks(4);                                            // n+12
        check("t1_halt_n12", 32'(Halt), 32'd1);
        check("t1_door_n12", 32'(Door_Open), 32'd0);

        // 2: SCAN keeps going up to 3 before turning round for 0
        RESET = 1'b1; ticks(1); RESET = 1'b0;
        Call_Req = 4'b1000;                                  // n
        ticks(1); Call_Req = '0;                             // n+1
        ticks(4);                                            // n+5
        check("t2_floor1_up", 32'(Current_Floor) + 32'(Go_Up) * 32'd10, 32'd11);
        Call_Req = 4'b0001;
        ticks(1); Call_Req = '0;                             // n+6
        check("t2_pend", 32'(Pending), 32'h9);
        ticks(5);                                            // n+11
        check("t2_floor3",  32'(Current_Floor), 32'd3);
        check("t2_door3",   32'(Door_Open), 32'd1);
        check("t2_pend3",   32'(Pending), 32'h1);
        ticks(5);                                            // n+16
        check("t2_godown",  32'(Go_Down), 32'd1);
        check("t2_dir",     32'(Dir_Up), 32'd0);
        ticks(9);                                            // n+25
        check("t2_floor0",  32'(Current_Floor), 32'd0);
        check("t2_door0",   32'(Door_Open), 32'd1);

        // 3: same-floor call at door count 1 extends the dwell
        ticks(2); Call_Req = 4'b0001;                        // n+27
        ticks(1); Call_Req = '0;                             // n+28
        check("t3_door_ext", 32'(Door_Open), 32'd1);
        check("t3_pend",     32'(Pending), 32'd0);
        ticks(3);                                            // n+31
        check("t3_door_late", 32'(Door_Open), 32'd1);
        ticks(1);                                            // n+32
        check("t3_door_end", 32'(Door_Open), 32'd0);

        // 4: top limit while moving up from floor 2
        Call_Req = 4'b1000;                                  // m
        ticks(1); Call_Req = '0;                             // m+1
        ticks(7);                                            // m+8
        check("t4_floor2", 32'(Current_Floor), 32'd2);
        Top_Limit_Hit = 1'b1;
        ticks(1); Top_Limit_Hit = 1'b0;                      // m+9
        check("t4_floor3", 32'(Current_Floor), 32'd3);
        check("t4_door",   32'(Door_Open), 32'd1);
        ticks(4);                                            // m+13
        Bottom_Limit_Hit = 1'b1;
        ticks(1); Bottom_Limit_Hit = 1'b0;
        check("t4_bot_resync", 32'(Current_Floor), 32'd0);
        check("t4_bot_halt",   32'(Halt), 32'd1);
        Top_Limit_Hit = 1'b1;
        ticks(1); Top_Limit_Hit = 1'b0;
        check("t4_top_resync", 32'(Current_Floor), 32'd3);

        // 5: reset in the middle of a descent
        Call_Req = 4'b0001;                                  // p
        ticks(1); Call_Req = '0;                             // p+1
        ticks(1);                                            // p+2
        check("t5_godown", 32'(Go_Down), 32'd1);
        ticks(3);                                            // p+5
        check("t5_floor2", 32'(Current_Floor), 32'd2);
        RESET = 1'b1;
        ticks(1);                                            // p+6
        check("t5_halt",  32'(Halt), 32'd1);
        check("t5_pend",  32'(Pending), 32'd0);
        check("t5_floor", 32'(Current_Floor), 32'd0);
        check("t5_dir",   32'(Dir_Up), 32'd1);
        RESET = 1'b0;

        // 6: calls everywhere from floor 0
        Call_Req = 4'b1111;                                  // q
        ticks(1); Call_Req = '0;                             // q+1
        check("t6_door0", 32'(Door_Open), 32'd1);
        check("t6_pend0", 32'(Pending), 32'he);
        ticks(8);                                            // q+9
        check("t6_floor1", 32'(Current_Floor) + 32'(Door_Open) * 32'd10, 32'd11);
        ticks(8);                                            // q+17
        check("t6_floor2", 32'(Current_Floor) + 32'(Door_Open) * 32'd10, 32'd12);
        check("t6_pend2",  32'(Pending), 32'h8);
        ticks(8);                                            // q+25
        check("t6_floor3", 32'(Current_Floor) + 32'(Door_Open) * 32'd10, 32'd13);
        check("t6_pend3",  32'(Pending), 32'd0);
        ticks(4);                                            // q+29
        check("t6_idle",   32'(Halt) + 32'(Door_Open) * 32'd10, 32'd1);

        ticks(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
